// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, opcodes, response entry type and opcode legality check
package alu_pkg;

    localparam int ALU_W = 32;
    localparam int OP_W  = 4;
    localparam int SHW   = $clog2(ALU_W);

    localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b1010;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b1100;
    localparam logic [OP_W-1:0] OP_SLTU = 4'b1101;

    typedef struct packed {
        logic [ALU_W-1:0] out;
        logic             zero;
        logic             err;
    } rsp_entry_t;

    function automatic logic alu_op_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SLL, OP_SUB,
            OP_SRL, OP_SRA, OP_SLT, OP_NOR, OP_SLTU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_alu.sv
// rtl/alu_cmd_issuer_alu.sv - combinational ALU driven by the issuer operand registers
//   A, B  in   ALU_W  operands
//   Op    in   OP_W   opcode
//   Out   out  ALU_W  result (0 for unassigned opcodes)
//   Zero  out  1      Out == 0
module alu_cmd_issuer_alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [OP_W-1:0]  Op,
    output logic [ALU_W-1:0] Out,
    output logic             Zero
);

    always_comb begin
        Out = '0;
        case (Op)
            OP_AND:  Out = A & B;
            OP_OR:   Out = A | B;
            OP_ADD:  Out = A + B;
            OP_XOR:  Out = A ^ B;
            OP_SLL:  Out = A << B[SHW-1:0];
            OP_SUB:  Out = A - B;
            OP_SRL:  Out = A >> B[SHW-1:0];
            OP_SRA:  Out = $unsigned($signed(A) >>> B[SHW-1:0]);
            OP_SLT:  Out = {{(ALU_W-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_NOR:  Out = ~(A | B);
            OP_SLTU: Out = {{(ALU_W-1){1'b0}}, (A < B)};
            default: Out = '0;
        endcase
    end

    assign Zero = (Out == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - registers ALU commands, runs the ALU and queues results in a credit-checked FIFO
//   clk, resetn            clock, async active-low reset
//   cmd_valid/ready, cmd_a, cmd_b, cmd_op   command handshake and payload
//   rsp_valid/ready, rsp_out, rsp_zero, rsp_err   result handshake and payload
//   op_count               results pushed, wraps modulo 2^CNT_W
//   Optional: ALU_OP_CHECK_EN flags illegal opcodes with rsp_err instead of passing them to the ALU
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ALU_W-1:0] cmd_a,
    input  logic [ALU_W-1:0] cmd_b,
    input  logic [OP_W-1:0]  cmd_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_out,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic [ALU_W-1:0] a_q;
    logic [ALU_W-1:0] b_q;
    logic [OP_W-1:0]  op_q;
    logic             in_flight;

    rsp_entry_t       mem [RSP_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [ALU_W-1:0] alu_out;
    logic             alu_zero;
    logic [OP_W-1:0]  alu_op;
    rsp_entry_t       push_entry;
    rsp_entry_t       head;

    logic             accept;
    logic             push;
    logic             pop;
    logic [CW:0]      credits_used;

    // Credit check uses registered state only, so rsp_ready never reaches
    // cmd_ready combinationally; the slot held by the in-flight command is
    // reserved so its push always finds room.
    assign credits_used = {1'b0, count} + {{CW{1'b0}}, in_flight};
    assign cmd_ready    = credits_used < (CW+1)'(RSP_DEPTH);

    assign accept    = cmd_valid & cmd_ready;
    assign push      = in_flight;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;

    alu_cmd_issuer_alu u_alu (
        .A    (a_q),
        .B    (b_q),
        .Op   (alu_op),
        .Out  (alu_out),
        .Zero (alu_zero)
    );

`ifdef ALU_OP_CHECK_EN
    logic op_legal;

    assign op_legal = alu_op_legal(op_q);
    // Illegal opcodes still occupy a slot; the ALU sees a harmless AND and
    // the entry reports the error with a cleared result.
    assign alu_op   = op_legal ? op_q : OP_AND;

    always_comb begin
        push_entry.out  = op_legal ? alu_out : '0;
        push_entry.zero = op_legal ? alu_zero : 1'b0;
        push_entry.err  = ~op_legal;
    end
`else
    assign alu_op = op_q;

    always_comb begin
        push_entry.out  = alu_out;
        push_entry.zero = alu_zero;
        push_entry.err  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            in_flight <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            op_count  <= '0;
        end else begin
            in_flight <= accept;
            if (accept) begin
                a_q  <= cmd_a;
                b_q  <= cmd_b;
                op_q <= cmd_op;
            end
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                op_count <= op_count + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; outputs are masked by rsp_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head     = mem[rd_ptr];
    assign rsp_out  = rsp_valid ? head.out  : '0;
    assign rsp_zero = rsp_valid ? head.zero : 1'b0;
    assign rsp_err  = rsp_valid ? head.err  : 1'b0;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - randomized self-checking bench for alu_cmd_issuer with a queue-based reference model
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [3:0]  cmd_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_out;
    logic        rsp_zero;
    logic        rsp_err;
    logic [15:0] op_count;

    alu_cmd_issuer #(.RSP_DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] out;
        logic        zero;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    exp_t        pend;
    bit          pend_v = 1'b0;
    logic [15:0] ops = '0;

    function automatic exp_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        exp_t        e;
        bit          legal;
        int unsigned sh;
        sh = b % 32;
`ifdef ALU_OP_CHECK_EN
        legal = (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13});
`else
        legal = 1'b1;
`endif
        e.err = !legal;
        e.out = 32'd0;
        if (legal) begin
            case (op)
                4'd0:  e.out = a & b;
                4'd1:  e.out = a | b;
                4'd2:  e.out = a + b;
                4'd3:  e.out = a ^ b;
                4'd4:  e.out = a * (32'd1 << sh);
                4'd6:  e.out = a + (~b + 32'd1);
                4'd8:  e.out = a / (32'd1 << sh);
                4'd9:  begin
                    e.out = a / (32'd1 << sh);
                    if (a[31]) e.out = e.out | ~(32'hFFFF_FFFF >> sh);
                end
                4'd10: e.out = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                4'd12: e.out = 32'hFFFF_FFFF ^ (a | b);
                4'd13: e.out = (a < b) ? 32'd1 : 32'd0;
                default: e.out = 32'd0;
            endcase
            e.zero = (e.out == 32'd0);
        end else begin
            e.zero = 1'b0;
        end
        return e;
    endfunction

    function automatic bit exp_ready();
        return (q.size() + int'(pend_v)) < 4;
    endfunction

    // Called at a negedge: applies inputs, advances the model across the next
    // rising edge, and returns at the following negedge.
    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input bit rr);
        bit acc;
        cmd_valid = v; cmd_a = a; cmd_b = b; cmd_op = op; rsp_ready = rr;
        acc = v && exp_ready();
        @(posedge clk);
        if (rr && q.size() > 0) void'(q.pop_front());
        if (pend_v) begin
            q.push_back(pend);
            ops = ops + 16'd1;
        end
        pend_v = acc;
        if (acc) pend = ref_alu(a, b, op);
        @(negedge clk);
    endtask

    task automatic model_clear();
        q.delete();
        pend_v = 1'b0;
        ops = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_out, rsp_zero, rsp_err, op_count} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b out=%h z=%0b e=%0b cnt=%0d want rdy=1 rest 0",
                     cmd_ready, rsp_valid, rsp_out, rsp_zero, rsp_err, op_count);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        drive(1, 32'h9876, 32'h1234, 4'b0000, 1);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_latency_n1: rsp_valid got %0b want 0", rsp_valid);
        end
        drive(0, 0, 0, 0, 1);
        checks++;
        if ({rsp_valid, rsp_out, rsp_zero, rsp_err} !== {1'b1, 32'h1034, 1'b0, 1'b0}) begin
            errors++; $display("FAIL single_result: got vld=%0b out=%h z=%0b e=%0b want 1 00001034 0 0",
                               rsp_valid, rsp_out, rsp_zero, rsp_err);
        end
        checks++;
        if (op_count !== 16'd1) begin
            errors++; $display("FAIL single_op_count: got %0d want 1", op_count);
        end
        drive(0, 0, 0, 0, 1);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: rsp_valid got %0b want 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 32'h9876, 32'h1234, 4'b0000, 1);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready0: got %0b want 1", cmd_ready);
        end
        drive(1, 32'h9876, 32'h1234, 4'b0001, 1);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_out} !== {1'b1, 1'b1, 32'h1034}) begin
            errors++; $display("FAIL b2b_first: got rdy=%0b vld=%0b out=%h want 1 1 00001034", cmd_ready, rsp_valid, rsp_out);
        end
        drive(0, 0, 0, 0, 1);
        checks++;
        if ({rsp_valid, rsp_out} !== {1'b1, 32'h9A76}) begin
            errors++; $display("FAIL b2b_second: got vld=%0b out=%h want 1 00009a76", rsp_valid, rsp_out);
        end
        drive(0, 0, 0, 0, 1);
        checks++;
        if ({rsp_valid, op_count} !== {1'b0, ops}) begin
            errors++; $display("FAIL b2b_drain: got vld=%0b cnt=%0d want 0 %0d", rsp_valid, op_count, ops);
        end
    endtask

    task automatic test_zero();
        drive(1, 32'h00FF, 32'hFF00, 4'b0000, 1);
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({rsp_valid, rsp_out, rsp_zero} !== {1'b1, 32'd0, 1'b1}) begin
            errors++; $display("FAIL zero_flag: got vld=%0b out=%h z=%0b want 1 00000000 1", rsp_valid, rsp_out, rsp_zero);
        end
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        int   accepted;
        exp_t held;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            if (cmd_ready === 1'b1) accepted++;
            drive(1, $urandom, $urandom, 4'($urandom_range(0, 2)), 0);
        end
        checks++;
        if (accepted != 4 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept: got accepted=%0d rdy=%0b want 4 0", accepted, cmd_ready);
        end
        held = q[0];
        repeat (2) drive(0, 0, 0, 0, 0);
        checks++;
        if ({rsp_valid, rsp_out, rsp_zero, rsp_err, cmd_ready} !== {1'b1, held, 1'b0}) begin
            errors++; $display("FAIL bp_hold: got vld=%0b out=%h z=%0b e=%0b rdy=%0b want 1 %h %0b %0b 0",
                               rsp_valid, rsp_out, rsp_zero, rsp_err, cmd_ready, held.out, held.zero, held.err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rsp_valid, rsp_out, rsp_zero, rsp_err} !== {1'b1, q[0]}) begin
                errors++; $display("FAIL bp_drain%0d: got vld=%0b out=%h z=%0b e=%0b want 1 %h %0b %0b",
                                   i, rsp_valid, rsp_out, rsp_zero, rsp_err, q[0].out, q[0].zero, q[0].err);
            end
            drive(0, 0, 0, 0, 1);
            if (i == 0) begin
                checks++;
                if (cmd_ready !== 1'b1) begin
                    errors++; $display("FAIL bp_ready_return: got %0b want 1", cmd_ready);
                end
            end
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_empty: rsp_valid got %0b want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1, $urandom, $urandom, 4'd2, 0);
        drive(0, 0, 0, 0, 0);
        cmd_valid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({rsp_valid, op_count, cmd_ready} !== {1'b0, 16'd0, 1'b1}) begin
            errors++; $display("FAIL midreset_immediate: got vld=%0b cnt=%0d rdy=%0b want 0 0 1", rsp_valid, op_count, cmd_ready);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            checks++;
            if ({rsp_valid, op_count} !== {1'b0, 16'd0}) begin
                errors++; $display("FAIL midreset_stale%0d: got vld=%0b cnt=%0d want 0 0", i, rsp_valid, op_count);
            end
        end
    endtask

    task automatic test_illegal_op();
        exp_t e;
        drive(1, 32'h0000_0005, 32'h0000_0003, 4'b1111, 1);
        drive(1, 32'h0000_0005, 32'h0000_0003, 4'b0010, 1);
        e = ref_alu(32'h5, 32'h3, 4'b1111);
        checks++;
`ifdef ALU_OP_CHECK_EN
        if ({rsp_valid, rsp_err, rsp_out, rsp_zero} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin
            errors++; $display("FAIL illegal_entry: got vld=%0b e=%0b out=%h z=%0b want 1 1 00000000 0", rsp_valid, rsp_err, rsp_out, rsp_zero);
        end
`else
        if ({rsp_valid, rsp_err, rsp_out, rsp_zero} !== {1'b1, 1'b0, e.out, e.zero}) begin
            errors++; $display("FAIL illegal_entry: got vld=%0b e=%0b out=%h z=%0b want 1 0 %h %0b", rsp_valid, rsp_err, rsp_out, rsp_zero, e.out, e.zero);
        end
`endif
        drive(0, 0, 0, 0, 1);
        checks++;
        if ({rsp_valid, rsp_err, rsp_out} !== {1'b1, 1'b0, 32'd8}) begin
            errors++; $display("FAIL illegal_next_legal: got vld=%0b e=%0b out=%h want 1 0 00000008", rsp_valid, rsp_err, rsp_out);
        end
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 300; i++) begin
            checks++;
            if (cmd_ready !== exp_ready() || rsp_valid !== (q.size() > 0) || op_count !== ops) begin
                errors++; $display("FAIL rand_ctrl%0d: got rdy=%0b vld=%0b cnt=%0d want %0b %0b %0d",
                                   i, cmd_ready, rsp_valid, op_count, exp_ready(), q.size() > 0, ops);
            end
            if (q.size() > 0) begin
                checks++;
                if ({rsp_out, rsp_zero, rsp_err} !== q[0]) begin
                    errors++; $display("FAIL rand_data%0d: got out=%h z=%0b e=%0b want %h %0b %0b",
                                       i, rsp_out, rsp_zero, rsp_err, q[0].out, q[0].zero, q[0].err);
                end
            end
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            drive($urandom_range(0, 3) != 0, a, b, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_illegal_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
